// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-multiply subsystem: the default element
// width, the result-drain state encoding, and the index-width helper used by
// the engine, the result drain and the operand loader.
// No ports (package).
// -----------------------------------------------------------------------------
package matmul_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // Index width for a dimension of n entries; never narrower than one bit
    // so that a size-1 dimension still has a legal (constant-zero) index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_result_drain.sv
// -----------------------------------------------------------------------------
// matmul_result_drain
// Captures the matrix-multiply engine's parallel result array when the engine
// pulses done, then streams the captured copy out one element per valid/ready
// handshake in row-major order. This frees the engine output immediately.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   done           single-cycle capture pulse; result valid in that cycle
//   result         packed [row][col][bit] result array
//   out_data       current element (0 while out_valid is low)
//   out_valid      out_data valid
//   out_ready      downstream accepts the current element
//   out_row/col    indices of the current element
//   out_row_last   current element is the last of its row
//   out_last       current element is the last of the matrix
//   busy           buffer holds undrained data
//   overrun        sticky: a done was dropped while busy
//   clr_overrun    clears overrun (a simultaneous new overrun wins)
// -----------------------------------------------------------------------------
module matmul_result_drain
    import matmul_pkg::*;
#(
    parameter int LEFT_SIZE  = 2,
    parameter int RIGHT_SIZE = 4,
    parameter int DATA_W     = DATA_W_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  done,
    input  logic [LEFT_SIZE*RIGHT_SIZE*DATA_W-1:0] result,
    output logic [DATA_W-1:0]                     out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [idx_w(LEFT_SIZE)-1:0]           out_row,
    output logic [idx_w(RIGHT_SIZE)-1:0]          out_col,
    output logic                                  out_row_last,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  overrun,
    input  logic                                  clr_overrun
);

    localparam int ROW_W = idx_w(LEFT_SIZE);
    localparam int COL_W = idx_w(RIGHT_SIZE);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(LEFT_SIZE - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(RIGHT_SIZE - 1);

    drain_state_t     state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             overrun_q, overrun_d;

    logic [DATA_W-1:0] buf_q [LEFT_SIZE][RIGHT_SIZE];

    logic streaming;
    logic xfer;
    logic at_row_last;
    logic at_last;
    logic load;
    logic ovr_set;

    assign streaming   = (state_q == STREAM);
    assign xfer        = streaming && out_ready;
    assign at_row_last = (col_q == COL_MAX);
    assign at_last     = at_row_last && (row_q == ROW_MAX);

    // ---- capture buffer: data only, no reset (contents are don't-care) ----
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < LEFT_SIZE; i++) begin
                for (int j = 0; j < RIGHT_SIZE; j++) begin
                    buf_q[i][j] <= result[(i*RIGHT_SIZE + j)*DATA_W +: DATA_W];
                end
            end
        end
    end

    // ---- control next-state ----
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        load    = 1'b0;
        ovr_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (done) begin
                    load    = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (at_last) begin
                        row_d = '0;
                        col_d = '0;
                        // A done landing on the final beat is a back-to-back
                        // matrix: reload and keep streaming without a bubble.
                        if (done) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (at_row_last) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                // Any other done while streaming would clobber undrained data.
                if (done && !(xfer && at_last)) begin
                    ovr_set = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Set has priority over clear so a coincident drop is never lost.
    assign overrun_d = ovr_set | (overrun_q & ~clr_overrun);

    // ---- control registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    // ---- outputs: pure functions of registered state, so they hold while stalled ----
    assign out_valid    = streaming;
    assign busy         = streaming;
    assign out_data     = streaming ? buf_q[row_q][col_q] : '0;
    assign out_row      = row_q;
    assign out_col      = col_q;
    assign out_row_last = streaming && at_row_last;
    assign out_last     = streaming && at_last;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_matmul_result_drain.sv
module tb_matmul_result_drain;

    localparam int L  = 2;
    localparam int R  = 4;
    localparam int N  = L * R;
    localparam int W  = 32;
    localparam int RW = 1;
    localparam int CW = 2;

    logic             clk;
    logic             rst_n;
    logic             done;
    logic [N*W-1:0]   result;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_row;
    logic [CW-1:0]    out_col;
    logic             out_row_last;
    logic             out_last;
    logic             busy;
    logic             overrun;
    logic             clr_overrun;

    int total = 0;
    int bad   = 0;

    matmul_result_drain #(.LEFT_SIZE(L), .RIGHT_SIZE(R), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .done(done), .result(result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_row_last(out_row_last),
        .out_last(out_last), .busy(busy), .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel: 0 = incrementing 0x100*i+j, 1 = all 0xDEAD, 2 = all 0xBEEF, 3 = random
    function automatic logic [N*W-1:0] mk_mat(input int sel);
        logic [N*W-1:0] m;
        logic [W-1:0]   e;
        m = '0;
        for (int i = 0; i < L; i++) begin
            for (int j = 0; j < R; j++) begin
                case (sel)
                    0:       e = W'(32'h100 * i + j);
                    1:       e = 32'hDEAD;
                    2:       e = 32'hBEEF;
                    default: e = $urandom;
                endcase
                m[(i*R + j)*W +: W] = e;
            end
        end
        return m;
    endfunction

    task automatic chk(input string nm, input bit v, input logic [W-1:0] d,
                       input int r, input int c, input bit rl, input bit lst,
                       input bit b, input bit o);
        logic [RW-1:0] wr;
        logic [CW-1:0] wc;
        wr = RW'(r);
        wc = CW'(c);
        total++;
        if (out_valid !== v || out_data !== d || out_row !== wr || out_col !== wc ||
            out_row_last !== rl || out_last !== lst || busy !== b || overrun !== o) begin
            bad++;
            $display("FAIL %s: got v=%b d=%h r=%0d c=%0d rl=%b l=%b busy=%b ovr=%b; want v=%b d=%h r=%0d c=%0d rl=%b l=%b busy=%b ovr=%b",
                     nm, out_valid, out_data, out_row, out_col, out_row_last, out_last, busy, overrun,
                     v, d, wr, wc, rl, lst, b, o);
        end
    endtask

    // Expected beat k of the incrementing matrix, checked at the current cycle.
    task automatic chk_beat(input string nm, input int k, input bit o);
        chk(nm, 1'b1, W'(32'h100 * (k / R) + (k % R)), k / R, k % R,
            (k % R) == R - 1, k == N - 1, 1'b1, o);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- table of per-cycle vectors ----------------
    typedef struct {
        bit          dn;
        int          sel;
        bit          rdy;
        bit          clr;
        bit          v;
        logic [W-1:0] data;
        int          row;
        int          col;
        bit          rl;
        bit          last;
        bit          busy;
        bit          ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic add_idle(input bit dn, input int sel, input bit clr, input bit ovr);
        vec_t e;
        e.dn = dn; e.sel = sel; e.rdy = 1'b1; e.clr = clr;
        e.v = 1'b0; e.data = '0; e.row = 0; e.col = 0;
        e.rl = 1'b0; e.last = 1'b0; e.busy = 1'b0; e.ovr = ovr;
        tbl.push_back(e);
    endtask

    // kind 0: incrementing matrix, kind 1: all 0xBEEF
    task automatic add_beat(input int k, input int kind, input bit dn, input int sel,
                            input bit clr, input bit ovr);
        vec_t e;
        e.dn = dn; e.sel = sel; e.rdy = 1'b1; e.clr = clr;
        e.v = 1'b1;
        e.data = (kind == 1) ? 32'hBEEF : W'(32'h100 * (k / R) + (k % R));
        e.row = k / R; e.col = k % R;
        e.rl = (k % R) == R - 1; e.last = (k == N - 1);
        e.busy = 1'b1; e.ovr = ovr;
        tbl.push_back(e);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [W-1:0] m_mat [N];
    int           m_idx;
    bit           m_busy;
    bit           m_ovr;

    task automatic model_capture(input logic [N*W-1:0] res);
        for (int k = 0; k < N; k++) m_mat[k] = res[k*W +: W];
        m_idx  = 0;
        m_busy = 1'b1;
    endtask

    task automatic model_step(input bit dn, input bit rdy, input bit cl,
                              input logic [N*W-1:0] res);
        bit fire, fin, setv;
        fire = m_busy && rdy;
        fin  = fire && (m_idx == N - 1);
        setv = m_busy && dn && !fin;
        if (!m_busy) begin
            if (dn) model_capture(res);
        end else if (fire) begin
            if (fin) begin
                if (dn) model_capture(res);
                else begin
                    m_busy = 1'b0;
                    m_idx  = 0;
                end
            end else begin
                m_idx++;
            end
        end
        if (setv)     m_ovr = 1'b1;
        else if (cl)  m_ovr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit           pat [6] = '{1, 0, 0, 1, 0, 1};
        int           got;
        bit           stalled;
        logic [W-1:0] s_d;
        logic [RW-1:0] s_r;
        logic [CW-1:0] s_c;
        logic         s_rl, s_l;
        bit           dn, rdy, cl;
        logic [N*W-1:0] res;

        rst_n = 1'b0; done = 1'b0; result = '0; out_ready = 1'b0; clr_overrun = 1'b0;
        tick;
        chk("reset", 0, '0, 0, 0, 0, 0, 0, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("idle_after_reset", 0, '0, 0, 0, 0, 0, 0, 0);

        // Straight stream
        add_idle(1, 0, 0, 0);
        for (int k = 0; k < N; k++) add_beat(k, 0, 0, 3, 0, 0);
        add_idle(0, 3, 0, 0);
        // Dropped done (0xDEAD) at beat 3, then clear
        add_idle(1, 0, 0, 0);
        for (int k = 0; k < N; k++) add_beat(k, 0, k == 2, (k == 2) ? 1 : 3, 0, k > 2);
        add_idle(0, 3, 1, 1);
        add_idle(0, 3, 0, 0);
        // done (0xBEEF) on the final transfer: no bubble
        add_idle(1, 0, 0, 0);
        for (int k = 0; k < N; k++) add_beat(k, 0, k == N - 1, (k == N - 1) ? 2 : 3, 0, 0);
        for (int k = 0; k < N; k++) add_beat(k, 1, 0, 3, 0, 0);
        add_idle(0, 3, 0, 0);
        // clear coinciding with a dropped done: set wins; lone clear next cycle
        add_idle(1, 0, 0, 0);
        for (int k = 0; k < N; k++) add_beat(k, 0, k == 0, (k == 0) ? 1 : 3, k < 2, k == 1);
        add_idle(0, 3, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            done        = tbl[i].dn;
            result      = mk_mat(tbl[i].sel);
            out_ready   = tbl[i].rdy;
            clr_overrun = tbl[i].clr;
            chk($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].data, tbl[i].row, tbl[i].col,
                tbl[i].rl, tbl[i].last, tbl[i].busy, tbl[i].ovr);
            tick;
        end
        done = 1'b0; clr_overrun = 1'b0;

        // ---- ready pattern 1,0,0,1,0,1 with hold checks ----
        done = 1'b1; result = mk_mat(0); out_ready = 1'b0;
        tick;
        done = 1'b0; result = mk_mat(3);
        got = 0; stalled = 1'b0;
        s_d = '0; s_r = '0; s_c = '0; s_rl = 1'b0; s_l = 1'b0;
        for (int c = 0; c < 60 && got < N; c++) begin
            out_ready = pat[c % 6];
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== s_d || out_row !== s_r ||
                    out_col !== s_c || out_row_last !== s_rl || out_last !== s_l) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h r=%0d c=%0d, want v=1 d=%h r=%0d c=%0d",
                             out_valid, out_data, out_row, out_col, s_d, s_r, s_c);
                end
            end
            if (out_valid !== 1'b1) begin
                total++; bad++;
                $display("FAIL pat_valid: got out_valid=%b before beat %0d, want 1", out_valid, got);
                stalled = 1'b0;
            end else if (out_ready) begin
                chk_beat($sformatf("pat_beat%0d", got), got, 0);
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                s_d = out_data; s_r = out_row; s_c = out_col; s_rl = out_row_last; s_l = out_last;
            end
            tick;
        end
        total++;
        if (got != N) begin
            bad++;
            $display("FAIL pat_count: got %0d beats, want %0d", got, N);
        end
        chk("pat_end", 0, '0, 0, 0, 0, 0, 0, 0);

        // ---- asynchronous reset mid-stream ----
        out_ready = 1'b1;
        done = 1'b1; result = mk_mat(0);
        tick;                                   // beat 0 showing
        done = 1'b0; result = mk_mat(3);
        tick;                                   // beat 1 showing
        done = 1'b1; result = mk_mat(1);
        tick;                                   // beat 2 showing
        done = 1'b0; result = mk_mat(3);
        chk_beat("rst_pre", 2, 1);
        tick; tick; tick;                       // beats 0..4 transferred, beat 5 showing
        tick;                                   // beat 5 transferred
        chk_beat("rst_pre6", 6, 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 0, '0, 0, 0, 0, 0, 0, 0);
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("rst_noresume", 0, '0, 0, 0, 0, 0, 0, 0);
            tick;
        end
        done = 1'b1; result = mk_mat(0);
        tick;
        done = 1'b0; result = mk_mat(3);
        for (int k = 0; k < N; k++) begin
            chk_beat($sformatf("rst_restart%0d", k), k, 0);
            tick;
        end
        chk("rst_restart_end", 0, '0, 0, 0, 0, 0, 0, 0);

        // ---- randomized run against the reference model ----
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        m_busy = 1'b0; m_idx = 0; m_ovr = 1'b0;
        for (int k = 0; k < N; k++) m_mat[k] = '0;
        for (int c = 0; c < 3000; c++) begin
            dn  = ($urandom % 7) == 0;
            rdy = ($urandom % 4) != 0;
            cl  = ($urandom % 13) == 0;
            res = mk_mat(3);
            done = dn; out_ready = rdy; clr_overrun = cl; result = res;
            chk($sformatf("rand%0d", c), m_busy, m_busy ? m_mat[m_idx] : '0,
                m_busy ? m_idx / R : 0, m_busy ? m_idx % R : 0,
                m_busy && (m_idx % R) == R - 1, m_busy && m_idx == N - 1,
                m_busy, m_ovr);
            model_step(dn, rdy, cl, res);
            tick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_result_drain.md
Name: matmul_result_drain

Overview:
- Reader at the output end of the matrix-multiply engine.
- When the engine pulses done, the block captures its full parallel result array (LEFT_SIZE x RIGHT_SIZE words) into a local buffer.
- It then streams the buffer out one element per handshake, row-major, on a valid/ready interface.
- This frees the engine's output for the next operation and gives downstream logic (writeback, DMA, accumulators) a narrow stream.

Parameters:
- LEFT_SIZE, 2, number of result rows (>=1)
- RIGHT_SIZE, 4, number of result columns (>=1)
- DATA_W, 32, bits per result element

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- done  in  1  single-cycle pulse from matmul; result is valid in that cycle
- result  in  LEFT_SIZE*RIGHT_SIZE*DATA_W  packed [row][col][bit] result array
- out_data  out  DATA_W  current element
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_row  out  max(1,$clog2(LEFT_SIZE))  row index of out_data
- out_col  out  max(1,$clog2(RIGHT_SIZE))  column index of out_data
- out_row_last  out  1  element is last in its row
- out_last  out  1  element is last of matrix
- busy  out  1  buffer holds undrained data
- overrun  out  1  sticky: done arrived while busy and was dropped
- clr_overrun  in  1  clears overrun

Behaviour:
- Interface (already decided): reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - all outputs 0; state IDLE; row/col counters 0.
  - Buffer contents are don't-care, but out_data must read 0 while out_valid=0.
- States:
  - IDLE: done=1 -> capture result into buffer, row=col=0, go to STREAM.
  - STREAM: out_valid=1, busy=1.
- Latency: out_valid rises the cycle after done is sampled (1 cycle).
- Data path:
  - out_data = buf[row][col].
  - out_row_last = (col==RIGHT_SIZE-1).
  - out_last = out_row_last && (row==LEFT_SIZE-1).
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and all index/flag outputs hold stable.
  - out_valid never drops without a transfer.
- Advance on transfer: col++; when col==RIGHT_SIZE-1, col=0 and row++.
- Final transfer (out_last): go to IDLE; out_valid=0 next cycle; counters return to 0.
- done while STREAM and not on the final-transfer cycle:
  - ignored; buffer untouched; overrun set to 1 next cycle.
- done in the same cycle as the final transfer:
  - accepted; new capture, counters to 0, stay in STREAM with out_valid continuously high (no bubble); overrun unaffected.
- overrun:
  - cleared by clr_overrun; if set and clear events coincide, set wins.
  - not cleared by returning to IDLE.
- Degenerate sizes:
  - RIGHT_SIZE=1: out_row_last high on every element.
  - LEFT_SIZE=RIGHT_SIZE=1: single-beat matrix; out_last high on it.
- Reset mid-stream: out_valid, busy and overrun drop asynchronously; the partial matrix is discarded; no resume after reset release.
- No arithmetic; widths pass through unchanged. Counters never exceed their size-1 bounds.

Decomposition:
- Shared package matmul_pkg:
  - DATA_W default constant.
  - drain_state_t enum {IDLE, STREAM}.
  - index-width helper function idx_w(n) = max(1,$clog2(n)), also used by the engine and the future operand loader.
- No sub-module needed. Buffer, element mux and FSM stay in one module (~150-200 lines).

Test Plan:
(Config L=2, R=4, DATA_W=32; element [i][j] = 0x100*i + j unless noted.)
- Single done pulse, out_ready=1 constant:
  - 8 beats on consecutive cycles, starting the cycle after done: 0x000, 0x001, 0x002, 0x003, 0x100, 0x101, 0x102, 0x103.
  - out_row_last on beats 4 and 8; out_last on beat 8 only; busy=0 and out_valid=0 the cycle after beat 8.
- out_ready pattern 1,0,0,1,0,1... during a stream:
  - same 8 values in order; data, indices and flags held constant through every stalled cycle; no value skipped or duplicated.
- Second done (matrix of all 0xDEAD) at beat 3 of a stream:
  - stream continues 0x002..0x103 unchanged; overrun=1 from next cycle; returns to IDLE after beat 8; overrun still 1.
- Second done (all 0xBEEF) in the same cycle as the beat-8 transfer:
  - out_valid stays high; next beat is 0xBEEF at row 0, col 0; 8 beats of 0xBEEF follow; overrun=0.
- rst_n asserted low mid-stream, after beat 5 is transferred:
  - out_valid, busy and overrun go 0 immediately.
  - After release, a new done streams from 0x000 with out_row=0, out_col=0.
- clr_overrun=1 in the same cycle as a dropped done: overrun=1. clr_overrun=1 alone next cycle: overrun=0 the following cycle.
